operand_accumulator: RTL and testbench
======================================

# operand_accumulator

Sequential front end for the ripple-carry `adder`. It accepts a length-prefixed burst of unsigned operands over a valid/ready stream and folds each operand into a running sum register through an `adder` instance. It presents the final sum, with a sticky overflow flag, on a valid/ready result port. It sits upstream of any consumer of multi-operand sums and is the only sequential wrapper around the adder.

## Interface
- C_WIDTH, 32, operand width in bits.
- C_ACC_WIDTH, 40, accumulator width in bits; must be ≥ C_WIDTH+1.
- C_LEN_WIDTH, 8, width of the burst-length field.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, no other reset.
- start  in  1  begin a burst; sampled only in IDLE.
- len  in  C_LEN_WIDTH  number of operands in the burst; sampled with start.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid & in_ready.
- in_data  in  C_WIDTH  unsigned operand.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_sum  out  C_ACC_WIDTH  accumulated sum, modulo 2^C_ACC_WIDTH.
- out_overflow  out  1  sticky; set if any addition in the burst carried out of C_ACC_WIDTH.
- busy  out  1  high in ACCUM and DONE.

## Operation
- **FSM states:** IDLE, ACCUM, DONE.
- **IDLE**
  - in_ready=0, out_valid=0, busy=0.
  - On start: acc←0, ovf←0, remaining←len.
  - If len==0, go to DONE; otherwise go to ACCUM.
- **ACCUM**
  - in_ready=1 combinationally in this state; no dependency on in_valid.
  - On each accepted beat:
    - acc←sum[C_ACC_WIDTH-1:0].
    - ovf←ovf | sum[C_ACC_WIDTH].
    - remaining←remaining−1.
  - If remaining==1 at the accepted beat, go to DONE.
  - in_valid low: hold all state; no timeout.
- **Adder instance:** sum comes from an `adder` with C_WIDTH=C_ACC_WIDTH.
  - Operand a = acc.
  - Operand b = in_data zero-extended to C_ACC_WIDTH.
  - The (C_ACC_WIDTH+1)-bit result gives sum and carry.
- **DONE**
  - out_valid=1, out_sum=acc, out_overflow=ovf.
  - All three outputs are stable until out_ready is seen.
  - On out_valid & out_ready, go to IDLE.
- **start outside IDLE:** ignored, including start in DONE in the same cycle as out_ready. The next burst needs start in IDLE.
- **len outside IDLE:** changes are ignored; only the value sampled with start matters.
- **in_data outside ACCUM:** ignored; in_ready stays 0 there.
- **Wrap-around:** the sum wraps modulo 2^C_ACC_WIDTH. Overflow is flagged, never saturated.

## Timing
- **Reset values:** state=IDLE, acc=0, ovf=0, remaining=0. Therefore in_ready=0, out_valid=0, out_sum=0, out_overflow=0, busy=0.
- **Reset mid-burst:** aborts immediately (asynchronous). No partial result is emitted. The next burst starts clean.
- **Start to in_ready:** start at cycle T gives in_ready=1 at T+1.
- **Throughput:** one operand per cycle under continuous in_valid.
- **Latency:** last operand accepted at cycle T gives out_valid=1 at T+1. An N-operand burst with no stalls occupies N+1 cycles from first acceptance to out_valid.
- **len==0:** start at T gives out_valid=1 and out_sum=0 at T+1.
- **Back-pressure:** out_ready held low keeps DONE indefinitely with outputs frozen.
- **Minimum gap:** DONE→IDLE costs one cycle. Minimum spacing between result handshake and next start acceptance is one cycle.
- **Paths:**
  - The adder path from acc to acc is single-cycle combinational.
  - No combinational path from in_valid to in_ready.
  - No combinational path from out_ready to out_valid.

## Test plan
All scenarios use C_WIDTH=8, C_ACC_WIDTH=10, C_LEN_WIDTH=4.

- **Basic burst:** start with len=4, operands 1,2,3,4 with in_valid continuous.
  - out_valid=1 one cycle after the 4th beat.
  - out_sum=10, out_overflow=0.
  - in_ready=0 in DONE.
- **Overflow:** len=5, operands 255,255,255,255,255 (sum 1275).
  - out_sum=1275−1024=251.
  - out_overflow=1.
- **Stalls:** len=3, operands 7,8,9 with in_valid gaps of 2 cycles.
  - out_sum=24.
  - acc unchanged during gaps.
  - out_valid one cycle after the 3rd beat.
- **Back-pressure and ignored start:** in DONE, hold out_ready=0 for 5 cycles and pulse start.
  - out_valid, out_sum and out_overflow stay stable.
  - start is ignored.
  - After out_ready: IDLE, busy=0.
- **Zero length:** len=0.
  - out_valid next cycle with out_sum=0, out_overflow=0.
  - in_ready never asserts.
- **Reset mid-burst:** deassert rst_n after the 2nd of 4 beats, then a new burst len=2 with 5,6.
  - All outputs are 0 during reset.
  - The new burst yields out_sum=11 with no residue from the aborted burst.

Source files
------------

// File: rtl/operand_accumulator.sv
// rtl/operand_accumulator.sv - length-prefixed burst accumulator around a ripple-carry adder
// Folds a burst of unsigned operands into a running sum and reports it with a sticky overflow flag.

module adder #(
  parameter int C_WIDTH = 32
) (
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  output logic [C_WIDTH:0]   sum
);

  logic [C_WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < C_WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign sum[C_WIDTH] = carry[C_WIDTH];

endmodule

module operand_accumulator #(
  parameter int C_WIDTH     = 32,
  parameter int C_ACC_WIDTH = 40,
  parameter int C_LEN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [C_LEN_WIDTH-1:0] len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [C_WIDTH-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [C_ACC_WIDTH-1:0] out_sum,
  output logic                   out_overflow,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [C_ACC_WIDTH-1:0] acc, acc_nxt;
  logic                   ovf, ovf_nxt;
  logic [C_LEN_WIDTH-1:0] remaining, remaining_nxt;

  logic [C_ACC_WIDTH-1:0] operand_ext;
  logic [C_ACC_WIDTH:0]   sum;

  assign operand_ext = {{(C_ACC_WIDTH-C_WIDTH){1'b0}}, in_data};

  adder #(
    .C_WIDTH (C_ACC_WIDTH)
  ) u_adder (
    .a   (acc),
    .b   (operand_ext),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      ovf       <= ovf_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Handshake outputs decode from state only, so in_valid/out_ready never loop back combinationally.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    ovf_nxt       = ovf;
    remaining_nxt = remaining;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt       = '0;
          ovf_nxt       = 1'b0;
          remaining_nxt = len;
          state_nxt     = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          acc_nxt       = sum[C_ACC_WIDTH-1:0];
          ovf_nxt       = ovf | sum[C_ACC_WIDTH];
          remaining_nxt = remaining - 1'b1;
          if (remaining == {{(C_LEN_WIDTH-1){1'b0}}, 1'b1}) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign out_sum      = acc;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_operand_accumulator.sv
// tb/tb_operand_accumulator.sv - scoreboard bench for operand_accumulator
// Directed bursts push expected results; a monitor pops and compares on each result handshake.

module tb_operand_accumulator;

  localparam int W  = 8;
  localparam int AW = 10;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_sum;
  logic          out_overflow;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [AW:0] exp_q[$];
  int ops[$];

  operand_accumulator #(
    .C_WIDTH     (W),
    .C_ACC_WIDTH (AW),
    .C_LEN_WIDTH (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every result handshake against the oldest pushed expectation.
  initial begin
    logic [AW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sum", 32'(out_sum), 32'(e[AW-1:0]));
          chk("sb_ovf", 32'(out_overflow), 32'(e[AW]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the burst in ops[]; gap idle cycles before each beat, hold cycles of back-pressure in DONE.
  task automatic run_burst(input int gap, input int hold, input int exp_sum, input int exp_ovf);
    int part;
    logic [AW-1:0] s0;
    logic o0;
    part = 0;
    exp_q.push_back({exp_ovf[0], exp_sum[AW-1:0]});
    start = 1'b1;
    len   = LW'(ops.size());
    tick();
    start = 1'b0;
    len   = 4'd9;
    if (ops.size() > 0) chk("start_to_in_ready", 32'(in_ready), 1);
    foreach (ops[i]) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("stall_acc_hold", 32'(out_sum), 32'(part));
      end
      in_valid = 1'b1;
      in_data  = W'(ops[i]);
      tick();
      in_valid = 1'b0;
      in_data  = 8'hAA;
      part = (part + ops[i]) % (1 << AW);
    end
    chk("latency_out_valid", 32'(out_valid), 1);
    chk("done_in_ready", 32'(in_ready), 0);
    chk("done_busy", 32'(busy), 1);
    s0 = out_sum;
    o0 = out_overflow;
    for (int h = 0; h < hold; h++) begin
      start = (h == 2);
      len   = 4'd3;
      tick();
      start = 1'b0;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_sum", 32'(out_sum), 32'(s0));
      chk("bp_ovf", 32'(out_overflow), 32'(o0));
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_out_valid", 32'(out_valid), 0);
    tick();
    chk("start_ignored_in_ready", 32'(in_ready), 0);
    chk("start_ignored_busy", 32'(busy), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_ovf", 32'(out_overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    ops = '{1, 2, 3, 4};
    run_burst(0, 0, 10, 0);

    ops = '{255, 255, 255, 255, 255};
    run_burst(0, 0, 251, 1);

    ops = '{7, 8, 9};
    run_burst(2, 0, 24, 0);

    ops = '{100, 200};
    run_burst(0, 5, 300, 0);

    ops = '{};
    run_burst(0, 0, 0, 0);

    // Abort a burst after two beats; nothing is expected from it.
    start = 1'b1;
    len   = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd50;
    tick();
    in_data  = 8'd60;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_sum", 32'(out_sum), 0);
    chk("midrst_out_ovf", 32'(out_overflow), 0);
    chk("midrst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    ops = '{5, 6};
    run_burst(0, 0, 11, 0);

    repeat (3) tick();
    chk("sb_all_results_seen", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
